name_entry_buffer: RTL and testbench

Writer side of the scrolling-name display path. Takes raw DE1-SoC push-buttons and slide switches and debounces the buttons. Appends, deletes or clears character codes in a DEPTH-entry character buffer. The scroller reads the buffer through a registered read port. It uses `length` to know how many characters to scroll.

---
 rtl/name_entry_buffer.sv | 168 ++++++++++++++++
 tb/tb_name_entry_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/name_entry_buffer.sv
// Debounced push-button front end feeding a fixed-depth character buffer
// that the name scroller reads through a registered read port.
`timescale 1ns/1ps

module name_entry_buffer_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, REL_PEND} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          sync_1, sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RELEASED: begin
                if (!sync_2) begin
                    state_next = PRESS_PEND;
                    cnt_next   = '0;
                end
            end
            PRESS_PEND: begin
                if (sync_2)
                    state_next = RELEASED;
                else if (cnt == CNT_LAST)
                    state_next = PRESSED;
                else
                    cnt_next = cnt + CW'(1);
            end
            PRESSED: begin
                if (sync_2) begin
                    state_next = REL_PEND;
                    cnt_next   = '0;
                end
            end
            REL_PEND: begin
                if (!sync_2)
                    state_next = PRESSED;
                else if (cnt == CNT_LAST)
                    state_next = RELEASED;
                else
                    cnt_next = cnt + CW'(1);
            end
            default: state_next = RELEASED;
        endcase
    end

    // The press event is the PRESS_PEND -> PRESSED transition itself, so it lasts one cycle.
    always_comb begin
        press = (state == PRESS_PEND) && !sync_2 && (cnt == CNT_LAST);
    end
endmodule

module name_entry_buffer #(
    parameter int DEPTH = 8,
    parameter int CHAR_W = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              key_add_n,
    input  logic              key_del_n,
    input  logic              key_clr_n,
    input  logic [CHAR_W-1:0] char_in,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_char,
    output logic [AW:0]       length,
    output logic              full,
    output logic              empty,
    output logic              wr_pulse,
    output logic              err_pulse
);
    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

    logic              add_ev, del_ev, clr_ev;
    logic [CHAR_W-1:0] entries [DEPTH];
    logic [AW-1:0]     tail_idx, last_idx;

    name_entry_buffer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_add (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n(key_add_n), .press(add_ev)
    );
    name_entry_buffer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_del (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n(key_del_n), .press(del_ev)
    );
    name_entry_buffer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(CLOCK_50), .rst_n(RESET_N), .key_n(key_clr_n), .press(clr_ev)
    );

    // Low AW bits of length address the next free slot; minus one wraps to DEPTH-1 when full.
    assign tail_idx = length[AW-1:0];
    assign last_idx = tail_idx - AW'(1);
    assign full     = (length == LEN_FULL);
    assign empty    = (length == '0);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                entries[i] <= '0;
            length    <= '0;
            wr_pulse  <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            wr_pulse  <= 1'b0;
            err_pulse <= 1'b0;
            if (clr_ev) begin
                for (int unsigned i = 0; i < DEPTH; i++)
                    entries[i] <= '0;
                length   <= '0;
                wr_pulse <= 1'b1;
            end else if (del_ev) begin
                if (!empty) begin
                    entries[last_idx] <= '0;
                    length            <= length - LEN_ONE;
                    wr_pulse          <= 1'b1;
                end else begin
                    err_pulse <= 1'b1;
                end
            end else if (add_ev) begin
                if (!full) begin
                    entries[tail_idx] <= char_in;
                    length            <= length + LEN_ONE;
                    wr_pulse          <= 1'b1;
                end else begin
                    err_pulse <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            rd_char <= '0;
        else
            rd_char <= ({1'b0, rd_addr} < length) ? entries[rd_addr] : '0;
    end
endmodule

// File: tb/tb_name_entry_buffer.sv
// Directed, table-driven bench for name_entry_buffer (DEPTH=8, DEBOUNCE_CYCLES=4).
`timescale 1ns/1ps

module tb_name_entry_buffer;
    localparam int OP_ADD = 0;
    localparam int OP_DEL = 1;
    localparam int OP_CLR = 2;

    typedef struct {
        int op;
        int ch;
        int len;
        int full;
        int empty;
        int dwr;
        int derr;
        int ra;
        int rd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_add_n = 1'b1;
    logic       key_del_n = 1'b1;
    logic       key_clr_n = 1'b1;
    logic [4:0] char_in = '0;
    logic [2:0] rd_addr = '0;
    logic [4:0] rd_char;
    logic [3:0] length;
    logic       full, empty, wr_pulse, err_pulse;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;
    int err_seen = 0;
    vec_t vecs[$];

    name_entry_buffer #(.DEPTH(8), .CHAR_W(5), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n),
        .key_add_n(key_add_n), .key_del_n(key_del_n), .key_clr_n(key_clr_n),
        .char_in(char_in), .rd_addr(rd_addr), .rd_char(rd_char),
        .length(length), .full(full), .empty(empty),
        .wr_pulse(wr_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    // Counts cycles each strobe was high; a stretched strobe shows as an extra count.
    always @(posedge clk) begin
        if (wr_pulse) wr_seen++;
        if (err_pulse) err_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_keys(input bit a, input bit d, input bit c);
        @(negedge clk);
        key_add_n = !a;
        key_del_n = !d;
        key_clr_n = !c;
        repeat (10) @(negedge clk);
        key_add_n = 1'b1;
        key_del_n = 1'b1;
        key_clr_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic add_vec(input int op, input int ch, input int len, input int dwr,
                           input int derr, input int ra, input int rd);
        vec_t v;
        v.op = op; v.ch = ch; v.len = len;
        v.full = (len == 8) ? 1 : 0;
        v.empty = (len == 0) ? 1 : 0;
        v.dwr = dwr; v.derr = derr; v.ra = ra; v.rd = rd;
        vecs.push_back(v);
    endtask

    initial begin
        int w0;
        int e0;

        // Clear, fill to full, overflow, drain to empty, underflow, clear-on-empty
        add_vec(OP_CLR, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add_vec(OP_ADD, i, i, 1, 0, i - 1, i);
        add_vec(OP_ADD, 31, 8, 0, 1, 7, 8);
        add_vec(OP_DEL, 0, 7, 1, 0, 7, 0);
        for (int k = 2; k <= 8; k++)
            add_vec(OP_DEL, 0, 8 - k, 1, 0, (k == 8) ? 0 : 7 - k, (k == 8) ? 0 : 8 - k);
        add_vec(OP_DEL, 0, 0, 0, 1, 0, 0);
        add_vec(OP_CLR, 0, 0, 1, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst length", int'(length), 0);
        chk("rst empty", int'(empty), 1);
        chk("rst full", int'(full), 0);
        chk("rst rd_char", int'(rd_char), 0);
        chk("rst wr_pulse", int'(wr_pulse), 0);
        chk("rst err_pulse", int'(err_pulse), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Bouncing add key followed by a clean hold
        char_in = 5'd3;
        w0 = wr_seen;
        for (int i = 0; i < 5; i++) begin
            key_add_n = 1'b0;
            repeat (2) @(negedge clk);
            key_add_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("bounce no add", int'(length), 0);
        key_add_n = 1'b0;
        repeat (10) @(negedge clk);
        key_add_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("bounce length", int'(length), 1);
        chk("bounce wr count", wr_seen - w0, 1);
        rd_addr = 3'd0;
        @(negedge clk);
        chk("bounce rd_char", int'(rd_char), 3);

        foreach (vecs[i]) begin
            w0 = wr_seen;
            e0 = err_seen;
            char_in = 5'(vecs[i].ch);
            case (vecs[i].op)
                OP_ADD:  do_keys(1'b1, 1'b0, 1'b0);
                OP_DEL:  do_keys(1'b0, 1'b1, 1'b0);
                default: do_keys(1'b0, 1'b0, 1'b1);
            endcase
            chk($sformatf("v%0d length", i), int'(length), vecs[i].len);
            chk($sformatf("v%0d full", i), int'(full), vecs[i].full);
            chk($sformatf("v%0d empty", i), int'(empty), vecs[i].empty);
            chk($sformatf("v%0d wr count", i), wr_seen - w0, vecs[i].dwr);
            chk($sformatf("v%0d err count", i), err_seen - e0, vecs[i].derr);
            rd_addr = 3'(vecs[i].ra);
            @(negedge clk);
            chk($sformatf("v%0d rd_char", i), int'(rd_char), vecs[i].rd);
        end

        // Simultaneous add+delete at length 3, then clear+add
        for (int i = 1; i <= 3; i++) begin
            char_in = 5'(i);
            do_keys(1'b1, 1'b0, 1'b0);
        end
        chk("pre-sim length", int'(length), 3);
        w0 = wr_seen;
        e0 = err_seen;
        char_in = 5'd4;
        do_keys(1'b1, 1'b1, 1'b0);
        chk("add+del length", int'(length), 2);
        chk("add+del wr count", wr_seen - w0, 1);
        chk("add+del err count", err_seen - e0, 0);
        rd_addr = 3'd2;
        @(negedge clk);
        chk("add+del rd slot2", int'(rd_char), 0);
        w0 = wr_seen;
        do_keys(1'b1, 1'b0, 1'b1);
        chk("clr+add length", int'(length), 0);
        chk("clr+add wr count", wr_seen - w0, 1);
        chk("clr+add empty", int'(empty), 1);

        // Read gating and one-cycle latency with buffer {7, 9}
        char_in = 5'd7;
        do_keys(1'b1, 1'b0, 1'b0);
        char_in = 5'd9;
        do_keys(1'b1, 1'b0, 1'b0);
        rd_addr = 3'd0;
        @(negedge clk);
        chk("sweep rd0", int'(rd_char), 7);
        rd_addr = 3'd1;
        #1;
        chk("sweep latency", int'(rd_char), 7);
        @(negedge clk);
        chk("sweep rd1", int'(rd_char), 9);
        rd_addr = 3'd2;
        @(negedge clk);
        chk("sweep rd2", int'(rd_char), 0);
        rd_addr = 3'd3;
        @(negedge clk);
        chk("sweep rd3", int'(rd_char), 0);

        // Reset while the delete key is mid-debounce at length 5
        do_keys(1'b0, 1'b0, 1'b1);
        for (int i = 11; i <= 15; i++) begin
            char_in = 5'(i);
            do_keys(1'b1, 1'b0, 1'b0);
        end
        rd_addr = 3'd0;
        @(negedge clk);
        chk("pre-reset length", int'(length), 5);
        chk("pre-reset rd_char", int'(rd_char), 11);
        key_del_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst length", int'(length), 0);
        chk("midrst empty", int'(empty), 1);
        chk("midrst full", int'(full), 0);
        chk("midrst rd_char", int'(rd_char), 0);
        chk("midrst wr_pulse", int'(wr_pulse), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0 = err_seen;
        w0 = wr_seen;
        repeat (6) @(negedge clk);
        chk("held del early", int'(err_pulse), 0);
        @(negedge clk);
        chk("held del err_pulse", int'(err_pulse), 1);
        chk("held del length", int'(length), 0);
        @(negedge clk);
        chk("held del err width", int'(err_pulse), 0);
        key_del_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("held del err count", err_seen - e0, 1);
        chk("held del wr count", wr_seen - w0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
